// File: rtl/divider_8bit_seq_if.sv
// Request/result bundle for the sequential divider.
interface divider_8bit_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Requester side: issues operands, observes status and result
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divider_8bit_seq.sv
// Sequential 8-bit unsigned restoring divider; each iteration's quotient bit
// is decided by an external magnitude comparator (A >= B).
module divider_8bit_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ITER  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  divider_8bit_seq_if.slave        bus,
  output logic [WIDTH-1:0]         cmp_a,
  output logic [WIDTH-1:0]         cmp_b,
  input  logic                     cmp_agb,
  input  logic                     cmp_aeb
);

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] trial_c;
  logic             ge_c;

  // Trial remainder: shift next dividend bit into the partial remainder
  assign trial_c = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign ge_c    = cmp_agb | cmp_aeb;

  // Comparator operands are only meaningful while iterating; park at 0 otherwise
  assign cmp_a = (state_q == RUN) ? trial_c : '0;
  assign cmp_b = (state_q == RUN) ? d_q     : '0;

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dz_q;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          d_d   = bus.divisor;
          cnt_d = '0;
          if (bus.divisor == '0) begin
            // Zero divisor: stage the saturated result and skip iterating
            q_d     = '1;
            r_d     = bus.dividend;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            q_d     = bus.dividend;
            r_d     = '0;
            dz_d    = 1'b0;
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
      end

      RUN: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        if (ge_c) begin
          r_d = trial_c - d_q;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = trial_c;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CW'(ITER - 1)) begin
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        done_d  = 1'b1;
        quot_d  = q_q;
        rem_d   = r_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_divider_8bit_seq.sv
// Self-checking bench for divider_8bit_seq: cycle-level reference model,
// per-cycle compare against it, and directed literal cases.
module tb_divider_8bit_seq;

  logic       clk;
  logic       rst_n;
  logic [7:0] cmp_a;
  logic [7:0] cmp_b;
  logic       cmp_agb;
  logic       cmp_aeb;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  divider_8bit_seq_if #(.WIDTH(8)) bus ();

  divider_8bit_seq #(.WIDTH(8), .ITER(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .cmp_a   (cmp_a),
    .cmp_b   (cmp_b),
    .cmp_agb (cmp_agb),
    .cmp_aeb (cmp_aeb)
  );

  // Comparator stage model
  assign cmp_agb = (cmp_a > cmp_b);
  assign cmp_aeb = (cmp_a == cmp_b);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: timing by cycle counts, results by plain arithmetic
  int         m_left;
  bit         m_pend;
  bit         m_done;
  logic [7:0] m_q, m_r, m_a, m_b;
  bit         m_dz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_pend = 0; m_done = 0;
      m_q = 0; m_r = 0; m_a = 0; m_b = 0; m_dz = 0;
    end else begin
      m_done = 0;
      if (m_pend) begin
        m_pend = 0;
        m_done = 1;
        if (m_b == 0) begin
          m_q = 8'hFF;
          m_r = m_a;
        end else begin
          m_q = 8'(int'(m_a) / int'(m_b));
          m_r = 8'(int'(m_a) % int'(m_b));
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_pend = 1;
      end else if (bus.start) begin
        m_a  = bus.dividend;
        m_b  = bus.divisor;
        m_dz = (bus.divisor == 0);
        if (bus.divisor == 0) m_pend = 1;
        else m_left = 8;
      end
    end
  end

  // Per-cycle compare of DUT against the model
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("busy", 32'(bus.busy), 32'(m_left > 0));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("quotient", 32'(bus.quotient), 32'(m_q));
      chk("remainder", 32'(bus.remainder), 32'(m_r));
      chk("div_by_zero", 32'(bus.div_by_zero), 32'(m_dz));
      if (m_left > 0) begin
        int i, rr, t;
        i  = 8 - m_left;
        rr = (int'(m_a) >> (8 - i)) % int'(m_b);
        t  = rr * 2 + ((int'(m_a) >> (7 - i)) & 1);
        chk("cmp_a trial", 32'(cmp_a), 32'(t));
        chk("cmp_b divisor", 32'(cmp_b), 32'(m_b));
      end else begin
        chk("cmp_a idle", 32'(cmp_a), 32'd0);
        chk("cmp_b idle", 32'(cmp_b), 32'd0);
      end
    end
  end

  // Issue one division from a negedge; return at the negedge where done is seen
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input bit lit,
                         input logic [7:0] eq, input logic [7:0] er, input bit edz,
                         input string tag);
    int lat;
    lat = -1;
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk({tag, " latency"}, 32'(lat), (b == 0) ? 32'd1 : 32'd9);
    if (lit) begin
      chk({tag, " q"}, 32'(bus.quotient), 32'(eq));
      chk({tag, " r"}, 32'(bus.remainder), 32'(er));
      chk({tag, " dz"}, 32'(bus.div_by_zero), 32'(edz));
    end
  endtask

  initial begin
    int lat;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #1;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset q", 32'(bus.quotient), 32'd0);
    chk("reset r", 32'(bus.remainder), 32'd0);
    chk("reset dz", 32'(bus.div_by_zero), 32'd0);
    chk("reset cmp_a", 32'(cmp_a), 32'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1;
    @(negedge clk);

    // Directed cases with hand-computed results
    run_div(8'd200, 8'd7,   1, 8'd28,  8'd4,  0, "200/7");
    run_div(8'd255, 8'd1,   1, 8'd255, 8'd0,  0, "255/1");
    run_div(8'd5,   8'd9,   1, 8'd0,   8'd5,  0, "5/9");
    run_div(8'd255, 8'd255, 1, 8'd1,   8'd0,  0, "255/255");
    run_div(8'd250, 8'd201, 1, 8'd1,   8'd49, 0, "250/201");
    run_div(8'd77,  8'd0,   1, 8'hFF,  8'd77, 1, "77/0");
    @(negedge clk);

    // Start held through RUN: new operands ignored, then accepted after done
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.dividend = 8'd100;
    bus.divisor  = 8'd3;
    lat = -1;
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("held latency", 32'(lat), 32'd9);
    chk("held q", 32'(bus.quotient), 32'd28);
    chk("held r", 32'(bus.remainder), 32'd4);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("b2b latency", 32'(lat), 32'd9);
    chk("b2b q", 32'(bus.quotient), 32'd33);
    chk("b2b r", 32'(bus.remainder), 32'd1);
    @(negedge clk);

    // Asynchronous reset in the middle of RUN
    bus.dividend = 8'd200;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-reset busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(bus.busy), 32'd0);
    chk("midrst done", 32'(bus.done), 32'd0);
    chk("midrst q", 32'(bus.quotient), 32'd0);
    chk("midrst r", 32'(bus.remainder), 32'd0);
    chk("midrst dz", 32'(bus.div_by_zero), 32'd0);
    chk("midrst cmp_a", 32'(cmp_a), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst no done", 32'(bus.done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("post-rst no done", 32'(bus.done), 32'd0);
    end
    run_div(8'd64, 8'd8, 1, 8'd8, 8'd0, 0, "64/8");

    // Randomized operands, occasional zero divisor, random idle gaps
    for (int n = 0; n < 60; n++) begin
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_div(a, b, 0, 8'd0, 8'd0, 0, "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_8bit_seq.md
Name: divider_8bit_seq

Overview:
- Sequential 8-bit unsigned restoring divider for the calculator datapath.
- Consumes the magnitude-comparator stage (`_8bitmagcom`, cascade inputs tied to equal) each iteration.
- Drives the comparator's A/B operands and reads its AGB/AEB flags to decide each quotient bit.
- Produces quotient and remainder for the display/result register after a fixed 8-iteration run.

Parameters:
- WIDTH, 8, operand/quotient/remainder width; the comparator stage is 8 bits, so only 8 is supported.
- ITER, 8, number of iterations; must equal WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  8  numerator; captured when start is accepted.
- divisor  input  8  denominator; captured when start is accepted.
- cmp_a  output  8  operand A to the comparator (trial partial remainder).
- cmp_b  output  8  operand B to the comparator (latched divisor).
- cmp_agb  input  1  comparator A>B, combinational from cmp_a/cmp_b.
- cmp_aeb  input  1  comparator A=B, combinational from cmp_a/cmp_b.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- quotient  output  8  result quotient.
- remainder  output  8  result remainder.
- div_by_zero  output  1  set when the accepted divisor was 0.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE; busy, done, div_by_zero, quotient, remainder, internal count and shift registers all 0.
- Reset mid-RUN aborts the operation; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1 and divisor != 0:
  - latch divisor into D and dividend into shift register Q;
  - clear partial remainder R; count=0;
  - clear div_by_zero; go to RUN.
- IDLE, start=1 and divisor == 0:
  - quotient=8'hFF, remainder=dividend, div_by_zero=1; go to DONE.
  - No RUN cycles are spent.
- RUN, one iteration per cycle:
  - trial T = {R[6:0], Q[7]}, driven combinationally on cmp_a; cmp_b = D.
  - ge = cmp_agb | cmp_aeb.
  - If ge: R <= T - D and Q <= {Q[6:0],1}; otherwise R <= T and Q <= {Q[6:0],0}.
  - count increments; after the 8th iteration (count==7) go to DONE.
  - Width rule: before each shift R < 2^i with i ≤ 7, so R[7] is always 0 when shifted and T never exceeds 8 bits. No carry/overflow path is needed.
- DONE:
  - quotient <= Q, remainder <= R (only on the non-zero-divisor path), done=1 for exactly this cycle.
  - Then go to IDLE.
- Latency: start accepted at edge 0; RUN on edges 1–8; done high in the cycle after edge 9. The divide-by-zero path gives done after edge 1.
- busy is high exactly in RUN.
- start while in RUN or DONE is ignored, not queued.
- quotient, remainder and div_by_zero hold until the next accepted start's DONE; div_by_zero clears when a start is accepted.
- cmp_a/cmp_b are don't-care outside RUN; drive 0 in IDLE/DONE.
- A new start in the IDLE cycle immediately after DONE is accepted (back-to-back operation).

Test Plan:
- Basic divide: dividend=200, divisor=7, start pulse → busy for 8 cycles, then done pulse with quotient=28, remainder=4, div_by_zero=0.
- Edge values, each case checking one done pulse and total latency of 9 cycles:
  - 255/1 → q=255, r=0;
  - 5/9 → q=0, r=5;
  - 255/255 → q=1, r=0;
  - 250/201 → q=1, r=49.
- Divide by zero: dividend=77, divisor=0 → done on next cycle, quotient=8'hFF, remainder=77, div_by_zero=1, busy never asserted.
- start ignored while busy: start=1 held for all of RUN with new operands 100/3 → first result 200/7 (28 r4) unchanged. With start still high in the IDLE cycle after DONE, 100/3 is accepted and yields 33 r1.
- Reset mid-operation: drop rst_n asynchronously (between clock edges) at RUN iteration 4 → all outputs 0 immediately, no done pulse. After release, start 64/8 → q=8, r=0.
- Comparator handshake: in every RUN cycle, cmp_b equals the latched divisor. A bench model of the comparator driving cmp_agb/cmp_aeb matches a golden restoring-division trace bit-for-bit.
